// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, key-length modes, FSM states, SBox and GF(2^8) helpers.
package aes_pkg;

    localparam int NB_BYTE = 8;
    localparam int N_BYTES = 16;

    localparam logic [1:0] AES_MODE_128 = 2'd0;
    localparam logic [1:0] AES_MODE_192 = 2'd1;
    localparam logic [1:0] AES_MODE_256 = 2'd2;

    typedef enum logic {IDLE, RUN} aes_fsm_t;

    // Entry 0 sits in the MSBs.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        int idx;
        idx = 255 - int'(x);
        return SBOX_TABLE[8*idx +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int nr_from_mode(input logic [1:0] mode);
        case (mode)
            AES_MODE_128: return 10;
            AES_MODE_192: return 12;
            default:      return 14;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_ladder_iterative_if.sv
// Start/result bundle of the iterative AES ladder; the core is the slave, the requester the master.
interface aes_round_ladder_iterative_if #(
    parameter int NB_BYTE    = 8,
    parameter int N_BYTES    = 16,
    parameter int MAX_ROUNDS = 14
) ();

    localparam int W = N_BYTES * NB_BYTE;

    logic                        i_valid;
    logic                        o_ready;
    logic [1:0]                  i_mode;
    logic [W-1:0]                i_state;
    logic [W-1:0]                i_data;
    logic [W*(MAX_ROUNDS+1)-1:0] i_round_key_vector;
    logic [W-1:0]                o_state;
    logic [W-1:0]                o_data;
    logic                        o_valid;

    modport master (
        output i_valid, i_mode, i_state, i_data, i_round_key_vector,
        input  o_ready, o_state, o_data, o_valid
    );

    modport slave (
        input  i_valid, i_mode, i_state, i_data, i_round_key_vector,
        output o_ready, o_state, o_data, o_valid
    );

endinterface

// File: rtl/aes_round_comb.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns (skipped on the last round), AddRoundKey.
module aes_round_comb import aes_pkg::*; (
    input  logic [N_BYTES*NB_BYTE-1:0] i_state,
    input  logic [N_BYTES*NB_BYTE-1:0] i_round_key,
    input  logic                       i_last_round,
    output logic [N_BYTES*NB_BYTE-1:0] o_state
);

    logic [7:0] sub_b [16];
    logic [7:0] shf_b [16];
    logic [7:0] mix_b [16];

    // Byte i of the block is bits [127-8i -: 8]; byte 4c+r is row r of column c.
    always_comb begin
        o_state = '0;
        for (int i = 0; i < 16; i++) begin
            sub_b[i] = sbox(i_state[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shf_b[4*c+r] = sub_b[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) begin
                mix_b[4*c+j] = xtime(shf_b[4*c+j])
                             ^ xtime(shf_b[4*c+(j+1)%4]) ^ shf_b[4*c+(j+1)%4]
                             ^ shf_b[4*c+(j+2)%4] ^ shf_b[4*c+(j+3)%4];
            end
        end
        for (int i = 0; i < 16; i++) begin
            o_state[127-8*i -: 8] = (i_last_round ? shf_b[i] : mix_b[i]) ^ i_round_key[127-8*i -: 8];
        end
    end

endmodule

// File: rtl/aes_round_ladder_iterative.sv
// Iterative AES-128/192/256 keystream core: one shared round reused nr times, result XORed with a captured data block.
// AES_LADDER_DATA_XOR_EN keeps the data register and drives o_data; without it o_data is tied to zero.
module aes_round_ladder_iterative #(
    parameter int NB_BYTE    = 8,
    parameter int N_BYTES    = 16,
    parameter int MAX_ROUNDS = 14
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_enable,
    aes_round_ladder_iterative_if.slave aes_if
);
    import aes_pkg::*;

    localparam int W     = N_BYTES * NB_BYTE;
    localparam int CNT_W = $clog2(MAX_ROUNDS + 1);

    aes_fsm_t         fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] nr_q, nr_d;
    logic [W-1:0]     state_reg_q, state_reg_d;
    logic [W-1:0]     o_state_q, o_state_d;
    logic             o_valid_q, o_valid_d;
    logic [W-1:0]     round_key;
    logic [W-1:0]     round_out;
    logic             last_round;
`ifdef AES_LADDER_DATA_XOR_EN
    logic [W-1:0]     data_reg_q, data_reg_d;
    logic [W-1:0]     o_data_q, o_data_d;
`endif

    // Keys are not latched: the requester holds the vector stable for the whole block.
    always_comb begin
        round_key = '0;
        for (int i = 0; i <= MAX_ROUNDS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                round_key = aes_if.i_round_key_vector[W*i +: W];
            end
        end
    end

    assign last_round = (cnt_q == nr_q);

    aes_round_comb u_round (
        .i_state      (state_reg_q),
        .i_round_key  (round_key),
        .i_last_round (last_round),
        .o_state      (round_out)
    );

    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        nr_d        = nr_q;
        state_reg_d = state_reg_q;
        o_state_d   = o_state_q;
        o_valid_d   = 1'b0;
`ifdef AES_LADDER_DATA_XOR_EN
        data_reg_d  = data_reg_q;
        o_data_d    = o_data_q;
`endif
        if (i_enable) begin
            case (fsm_q)
                IDLE: begin
                    if (aes_if.i_valid) begin
                        state_reg_d = aes_if.i_state ^ aes_if.i_round_key_vector[W-1:0];
                        nr_d        = CNT_W'(nr_from_mode(aes_if.i_mode));
                        cnt_d       = CNT_W'(1);
                        fsm_d       = RUN;
`ifdef AES_LADDER_DATA_XOR_EN
                        data_reg_d  = aes_if.i_data;
`endif
                    end
                end
                RUN: begin
                    state_reg_d = round_out;
                    cnt_d       = cnt_q + CNT_W'(1);
                    if (last_round) begin
                        o_state_d = round_out;
                        o_valid_d = 1'b1;
                        fsm_d     = IDLE;
`ifdef AES_LADDER_DATA_XOR_EN
                        o_data_d  = round_out ^ data_reg_q;
`endif
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            fsm_q       <= IDLE;
            cnt_q       <= '0;
            nr_q        <= '0;
            state_reg_q <= '0;
            o_state_q   <= '0;
            o_valid_q   <= 1'b0;
`ifdef AES_LADDER_DATA_XOR_EN
            data_reg_q  <= '0;
            o_data_q    <= '0;
`endif
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            nr_q        <= nr_d;
            state_reg_q <= state_reg_d;
            o_state_q   <= o_state_d;
            o_valid_q   <= o_valid_d;
`ifdef AES_LADDER_DATA_XOR_EN
            data_reg_q  <= data_reg_d;
            o_data_q    <= o_data_d;
`endif
        end
    end

    assign aes_if.o_ready = (fsm_q == IDLE);
    assign aes_if.o_state = o_state_q;
    assign aes_if.o_valid = o_valid_q;
`ifdef AES_LADDER_DATA_XOR_EN
    assign aes_if.o_data  = o_data_q;
`else
    assign aes_if.o_data  = '0;
`endif

endmodule

// File: tb/tb_aes_round_ladder_iterative.sv
// Bench for the iterative AES ladder: FIPS-197 vectors, stall, mid-run reset, back-to-back and random blocks vs a byte-level AES model.
module tb_aes_round_ladder_iterative;

    localparam int W  = 128;
    localparam int KV = W * 15;

    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CTR    = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    logic rst;
    logic en;

    aes_round_ladder_iterative_if #(.NB_BYTE(8), .N_BYTES(16), .MAX_ROUNDS(14)) bus ();

    aes_round_ladder_iterative #(.NB_BYTE(8), .N_BYTES(16), .MAX_ROUNDS(14)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .i_enable(en),
        .aes_if  (bus)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] sb [256];

    logic [127:0]  ks, od, ks_a, dat_a, dat_b;
    logic [KV-1:0] rkv;
    int            t;

    // ---------------- reference model (field arithmetic, byte arrays) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // SBox derived from the multiplicative inverse plus the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    function automatic int nk_of(input logic [1:0] mode);
        return (mode == 2'd0) ? 4 : (mode == 2'd1) ? 6 : 8;
    endfunction

    // Unused round-key slots are filled with junk so the key mux is exercised honestly.
    function automatic logic [KV-1:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   tw;
        logic [7:0]    rc;
        logic [KV-1:0] v;
        int            nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tw = w[i-1];
            if (i % nk == 0) begin
                tw = sub_word({tw[23:0], tw[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tw = sub_word(tw);
            end
            w[i] = w[i-nk] ^ tw;
        end
        for (int j = 0; j < KV/32; j++) v[32*j +: 32] = $urandom();
        for (int r = 0; r <= nr; r++) v[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return v;
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [KV-1:0] keys, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [127:0] k;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ keys[127-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            k = keys[128*r +: 128];
            for (int i = 0; i < 16; i++) u[i] = sb[s[(i + 4*(i%4)) % 16]];
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) begin
                    if (r != nr)
                        s[4*c+j] = gmul(u[4*c+j], 8'h02) ^ gmul(u[4*c+(j+1)%4], 8'h03)
                                 ^ u[4*c+(j+2)%4] ^ u[4*c+(j+3)%4];
                    else
                        s[4*c+j] = u[4*c+j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] exp_data(input logic [127:0] keystream, input logic [127:0] d);
`ifdef AES_LADDER_DATA_XOR_EN
        return keystream ^ d;
`else
        return (keystream ^ d) & 128'h0;
`endif
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- bench helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Runs one block; optionally stalls 3 cycles at round 5. A stray i_valid pulse is always sent mid-run.
    task automatic do_block(input string tag, input logic [1:0] mode, input logic [255:0] key,
                            input logic [127:0] ctr, input logic [127:0] dat, input bit stall,
                            output logic [127:0] ks_o, output logic [127:0] od_o);
        logic [KV-1:0]  keys;
        logic [127:0]   exp_ks;
        int             nr, n, exp_lat;
        nr      = nk_of(mode) + 6;
        keys    = expand(key, nk_of(mode));
        exp_ks  = ref_encrypt(ctr, keys, nr);
        exp_lat = nr + (stall ? 3 : 0);
        bus.i_mode             = mode;
        bus.i_round_key_vector = keys;
        bus.i_state            = ctr;
        bus.i_data             = dat;
        bus.i_valid            = 1'b1;
        chk({tag, "_rdy_before"}, 128'(bus.o_ready), 128'd1);
        step();
        bus.i_valid = 1'b0;
        bus.i_state = rnd128();
        bus.i_data  = rnd128();
        n = 0;
        do begin
            step();
            n++;
            if (n == 2) bus.i_valid = 1'b1;
            if (n == 3) bus.i_valid = 1'b0;
            if (stall && n == 4) en = 1'b0;
            if (stall && n == 7) en = 1'b1;
        end while (!bus.o_valid && n < 40);
        en = 1'b1;
        chk({tag, "_latency"}, 128'(n), 128'(exp_lat));
        chk({tag, "_o_state"}, bus.o_state, exp_ks);
        chk({tag, "_o_data"}, bus.o_data, exp_data(exp_ks, dat));
        chk({tag, "_rdy_at_valid"}, 128'(bus.o_ready), 128'd1);
        ks_o = bus.o_state;
        od_o = bus.o_data;
        step();
        chk({tag, "_pulse"}, 128'(bus.o_valid), 128'd0);
        chk({tag, "_hold"}, bus.o_state, exp_ks);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        build_sbox();
        rst = 1'b1;
        en  = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_mode  = 2'd0;
        bus.i_state = '0;
        bus.i_data  = '0;
        bus.i_round_key_vector = '0;
        repeat (3) step();
        chk("reset_o_ready", 128'(bus.o_ready), 128'd1);
        chk("reset_o_valid", 128'(bus.o_valid), 128'd0);
        chk("reset_o_state", bus.o_state, 128'd0);
        chk("reset_o_data", bus.o_data, 128'd0);
        rst = 1'b0;
        step();

        // No accept while disabled.
        bus.i_round_key_vector = expand(KEY128, 4);
        bus.i_state = CTR;
        bus.i_valid = 1'b1;
        en = 1'b0;
        repeat (2) step();
        chk("en_low_no_accept", 128'(bus.o_ready), 128'd1);
        bus.i_valid = 1'b0;
        en = 1'b1;
        step();

        do_block("aes128", 2'd0, KEY128, CTR, rnd128(), 1'b0, ks, od);
        chk("aes128_fips", ks, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        do_block("aes192", 2'd1, KEY192, CTR, rnd128(), 1'b0, ks, od);
        chk("aes192_fips", ks, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
        do_block("aes256", 2'd2, KEY256, CTR, '1, 1'b0, ks, od);
        chk("aes256_fips", ks, 128'h8ea2b7ca516745bfeafc49904b496089);
`ifdef AES_LADDER_DATA_XOR_EN
        chk("data_xor_fips", od, 128'h715d4835ae98ba401503b66fb4b69f76);
`else
        chk("data_xor_fips", od, 128'h0);
`endif
        do_block("stall", 2'd2, KEY256, CTR, rnd128(), 1'b1, ks, od);
        chk("stall_fips", ks, 128'h8ea2b7ca516745bfeafc49904b496089);

        // Reset during round 7 aborts the block.
        bus.i_mode = 2'd2;
        bus.i_round_key_vector = expand(KEY256, 8);
        bus.i_state = CTR;
        bus.i_data  = rnd128();
        bus.i_valid = 1'b1;
        step();
        bus.i_valid = 1'b0;
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_o_valid", 128'(bus.o_valid), 128'd0);
        chk("midrst_o_ready", 128'(bus.o_ready), 128'd1);
        chk("midrst_o_state", bus.o_state, 128'd0);
        chk("midrst_o_data", bus.o_data, 128'd0);
        t = 0;
        repeat (20) begin
            step();
            if (bus.o_valid) t++;
        end
        chk("midrst_no_valid", 128'(t), 128'd0);
        do_block("after_rst", 2'd1, KEY192, CTR, rnd128(), 1'b0, ks, od);
        chk("after_rst_fips", ks, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);

        // Back-to-back AES-128 then AES-256 with i_valid held high.
        dat_a = rnd128();
        dat_b = rnd128();
        rkv   = expand(KEY128, 4);
        ks_a  = ref_encrypt(CTR, rkv, 10);
        bus.i_mode = 2'd0;
        bus.i_round_key_vector = rkv;
        bus.i_state = CTR;
        bus.i_data  = dat_a;
        bus.i_valid = 1'b1;
        step();
        t = 0;
        while (!bus.o_valid && t < 40) begin
            step();
            t++;
        end
        chk("b2b_a_cycle", 128'(t), 128'd10);
        chk("b2b_a_ready", 128'(bus.o_ready), 128'd1);
        chk("b2b_a_state", bus.o_state, ks_a);
        chk("b2b_a_data", bus.o_data, exp_data(ks_a, dat_a));
        rkv = expand(KEY256, 8);
        bus.i_mode = 2'd2;
        bus.i_round_key_vector = rkv;
        bus.i_data = dat_b;
        do begin
            step();
            t++;
        end while (!bus.o_valid && t < 80);
        bus.i_valid = 1'b0;
        chk("b2b_b_cycle", 128'(t), 128'd25);
        chk("b2b_b_state", bus.o_state, 128'h8ea2b7ca516745bfeafc49904b496089);
        chk("b2b_b_data", bus.o_data, exp_data(128'h8ea2b7ca516745bfeafc49904b496089, dat_b));
        step();
        chk("b2b_idle_after", 128'(bus.o_ready), 128'd1);

        // Random keys, counters, data and modes (including mode 3).
        for (int i = 0; i < 8; i++) begin
            do_block($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)),
                     {rnd128(), rnd128()}, rnd128(), rnd128(), (i == 5), ks, od);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_round_ladder_iterative.md
# aes_round_ladder_iterative

Iterative, multi-key-length AES encryption core for the GCM datapath: one shared round stage reused over 10, 12 or 14 cycles, selected per block by a mode input. It produces the keystream from a counter block and XORs it with a captured data block, so it sits between the round-key expansion and the GHASH input. It is the parametrised, handshaked successor of the fixed AES-256 sequential ladder, and adds the following:

- runtime key length;
- a ready/valid protocol;
- a stall input;
- data XOR inside the block.

## Interface
Parameters:
- NB_BYTE, 8, bits per byte.
- N_BYTES, 16, bytes per state.
- MAX_ROUNDS, 14, largest round count supported. It sizes the key vector and the counter.

Ports:
- i_clock  in  1  single clock; all logic is on posedge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  clock enable. When low, all registers freeze.
- i_valid  in  1  start request. A block is accepted when i_valid && o_ready && i_enable.
- o_ready  out  1  core is idle and can accept a block.
- i_mode  in  2  key length: 0 = 10 rounds, 1 = 12 rounds, 2 and 3 = 14 rounds.
- i_state  in  N_BYTES*NB_BYTE  counter block.
- i_data  in  N_BYTES*NB_BYTE  plaintext block.
- i_round_key_vector  in  N_BYTES*NB_BYTE*(MAX_ROUNDS+1)  expanded keys. Round key 0 is in the LSBs.
- o_state  out  N_BYTES*NB_BYTE  keystream (the encrypted counter).
- o_data  out  N_BYTES*NB_BYTE  o_state ^ captured i_data.
- o_valid  out  1  one-cycle pulse; the result is valid on o_state and o_data.

## Operation
FSM states: IDLE and RUN. Round counter width is clog2(MAX_ROUNDS+1).

- **IDLE, on accept:**
  - state_reg <= i_state ^ rk[0];
  - data_reg <= i_data;
  - nr <= 10, 12 or 14 from i_mode;
  - cnt <= 1;
  - go to RUN.
- **RUN, per enabled cycle:** state_reg <= round(state_reg, rk[cnt]).
  - The round is SubBytes, ShiftRows, MixColumns, then AddRoundKey.
  - MixColumns is skipped when cnt == nr.
  - cnt increments each enabled cycle.
- **RUN, when cnt == nr:**
  - o_state <= round result;
  - o_data <= round result ^ data_reg;
  - o_valid <= 1;
  - go to IDLE.
- **Key vector:** the block does not latch the key vector. i_round_key_vector and i_mode must be held stable from the accept cycle until o_valid. The key word is a mux indexed by cnt.
- **Outputs:** o_state and o_data hold their last result until the next completion.
- **o_ready:** high exactly when the FSM is in IDLE.
- **Boundary conditions:**
  - i_valid while in RUN is ignored. It is not queued and raises no error.
  - i_enable low freezes the FSM, cnt, state_reg and data_reg. o_valid is not asserted on a frozen cycle. An o_valid pulse already asserted deasserts on the next cycle regardless of i_enable.
  - i_reset in the middle of a block aborts it. No o_valid is produced for the aborted block. The FSM returns to IDLE.
  - o_valid and acceptance can occur in the same cycle: on the completing edge the FSM enters IDLE, so o_ready is high together with o_valid.
- **Reset values:**
  - o_state = 0, o_data = 0, o_valid = 0, o_ready = 1;
  - cnt = 0, FSM in IDLE.

## Timing
- Accept at edge k → o_valid high after edge k+nr. Latency is 10, 12 or 14 enabled cycles.
- Back-to-back throughput is one block per nr+1 enabled cycles (accept cycle included).
- Each disabled cycle adds exactly one cycle to the latency.
- All outputs are registered, and there is no combinational path from inputs to outputs.
- The critical path is key mux, then SBox, then MixColumns, then XOR, all within one cycle.

## Configuration
- Macro: AES_LADDER_DATA_XOR_EN.
- **Defined:** data_reg exists, and o_data = keystream ^ captured i_data.
- **Undefined:** data_reg is removed and o_data is tied to 0. i_data is unused. o_state and all timing are unchanged.

## Structure
- **Shared package aes_pkg** holds:
  - NB_BYTE and N_BYTES;
  - the mode encoding constants AES_MODE_128/192/256;
  - function nr_from_mode(mode);
  - the FSM state typedef (IDLE, RUN);
  - the SBox table function.
- **Sub-module aes_round_comb:** a combinational single round with input i_last_round, which skips MixColumns. It is instanced once.
- **Top level** holds the FSM, the counter, the key mux and the output registers.

## Test plan
- **AES-128 (FIPS-197 C.1):** key 000102…0f, counter 00112233…eeff → o_valid 10 cycles after accept. o_state = 69c4e0d86a7b0430d8cdb78070b4c55a.
- **AES-192 and AES-256 (C.2 and C.3):** same counter block.
  - AES-192: o_state = dda97ca4864cdfe06eaf70a0ec0d7191 at 12 cycles.
  - AES-256: o_state = 8ea2b7ca516745bfeafc49904b496089 at 14 cycles.
- **Data XOR:** AES-256 vector with i_data = all ones → o_data = 715d4835ae98ba401503b66fb4b69f76. With the macro undefined, o_data = 0.
- **Stall:** i_enable low for 3 cycles during round 5 → o_valid at 17 cycles with the same result. i_valid pulses while busy are ignored.
- **Reset mid-run:** assert i_reset at round 7 → no o_valid is produced, o_ready = 1 and outputs are 0 on the next cycle. A following block completes correctly.
- **Back-to-back mixed modes:** AES-128 then AES-256, with i_valid held high.
  - The second accept happens in the same cycle as the first o_valid.
  - o_valid pulses occur at cycles 10 and 25.
